// File: rtl/bp_host_io_ctrl_if.sv
// I/O command/response channel between the core side and the host I/O controller.
// The master issues commands and accepts responses; the slave serves them.
interface bp_host_io_ctrl_if #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
);
  logic [paddr_width_p-1:0] cmd_addr;
  logic                     cmd_wr;
  logic [data_width_p-1:0]  cmd_data;
  logic                     cmd_v;
  logic                     cmd_yumi;
  logic [data_width_p-1:0]  resp_data;
  logic                     resp_v;
  logic                     resp_ready;

  modport master (
    output cmd_addr, cmd_wr, cmd_data, cmd_v, resp_ready,
    input  cmd_yumi, resp_data, resp_v
  );

  modport slave (
    input  cmd_addr, cmd_wr, cmd_data, cmd_v, resp_ready,
    output cmd_yumi, resp_data, resp_v
  );
endinterface

// File: rtl/bp_host_io_ctrl.sv
// Host I/O controller: per-core getchar RX FIFOs, shared putchar TX FIFO,
// sticky finish/fail flags and a status register behind a 1-entry response.
module bp_host_io_ctrl #(
  parameter int num_core_p = 4,
  parameter int paddr_width_p = 40,
  parameter int data_width_p = 64,
  parameter int rx_fifo_els_p = 8,
  parameter int tx_fifo_els_p = 16,
  parameter logic [63:0] host_base_addr_p = 64'h0010_0000,
  localparam int cw_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_host_io_ctrl_if.slave      io,
  input  logic [7:0]            rx_data_i,
  input  logic [cw_lp-1:0]      rx_core_i,
  input  logic                  rx_v_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic [cw_lp-1:0]      tx_core_o,
  output logic                  tx_v_o,
  input  logic                  tx_ready_i,
  output logic [num_core_p-1:0] finish_o,
  output logic [num_core_p-1:0] fail_o,
  output logic                  all_finished_o
);

  localparam int rx_aw_lp = (rx_fifo_els_p > 1) ? $clog2(rx_fifo_els_p) : 1;
  localparam int rx_cw_lp = $clog2(rx_fifo_els_p) + 1;
  localparam int tx_aw_lp = (tx_fifo_els_p > 1) ? $clog2(tx_fifo_els_p) : 1;
  localparam int tx_cw_lp = $clog2(tx_fifo_els_p) + 1;
  localparam logic [paddr_width_p-1:0] base_lp =
    host_base_addr_p[paddr_width_p-1:0];

  logic [7:0]          rx_mem  [num_core_p][rx_fifo_els_p];
  logic [rx_aw_lp-1:0] rx_rptr [num_core_p];
  logic [rx_aw_lp-1:0] rx_wptr [num_core_p];
  logic [rx_cw_lp-1:0] rx_cnt  [num_core_p];

  logic [cw_lp+7:0]    tx_mem  [tx_fifo_els_p];
  logic [tx_aw_lp-1:0] tx_rptr, tx_wptr;
  logic [tx_cw_lp-1:0] tx_cnt;

  logic                    hit, is_get, is_put, is_fin, is_stat;
  logic [3:0]              func;
  logic [cw_lp-1:0]        core, rx_sel;
  logic                    tx_full, slot_free, yumi;
  logic                    rx_push, rx_pop, rx_empty, tx_push, tx_pop;
  logic [num_core_p-1:0]   rx_push_v, rx_pop_v;
  logic [rx_cw_lp-1:0]     cur_rx_cnt;
  logic [data_width_p-1:0] resp_next, resp_data_q;
  logic                    resp_v_q, all_fin_q;
  logic [num_core_p-1:0]   finish_q, fail_q;

  assign hit  = io.cmd_addr[paddr_width_p-1:16] == base_lp[paddr_width_p-1:16];
  assign func = io.cmd_addr[15:12];
  assign core = (num_core_p == 1) ? '0 : io.cmd_addr[3 +: cw_lp];

  assign is_get  = hit & (func == 4'h0) & ~io.cmd_wr;
  assign is_put  = hit & (func == 4'h1) &  io.cmd_wr;
  assign is_fin  = hit & (func == 4'h2) &  io.cmd_wr;
  assign is_stat = hit & (func == 4'h3) & ~io.cmd_wr;

  assign tx_full   = tx_cnt == tx_cw_lp'(tx_fifo_els_p);
  assign slot_free = ~resp_v_q | io.resp_ready;
  // Gated by reset so the handshake drops the instant reset asserts.
  assign yumi = reset_n_i & io.cmd_v & slot_free & ~(is_put & tx_full);
  assign io.cmd_yumi = yumi;

  assign cur_rx_cnt = rx_cnt[core];
  assign rx_empty   = cur_rx_cnt == '0;
  assign rx_pop     = yumi & is_get & ~rx_empty;
  assign rx_sel     = (num_core_p == 1) ? '0 : rx_core_i;
  assign rx_ready_o = rx_cnt[rx_sel] != rx_cw_lp'(rx_fifo_els_p);
  assign rx_push    = rx_v_i & rx_ready_o;

  assign tx_v_o  = tx_cnt != '0;
  assign tx_pop  = tx_v_o & tx_ready_i;
  assign tx_push = yumi & is_put;
  assign {tx_core_o, tx_data_o} = tx_mem[tx_rptr];

  always_comb begin
    rx_push_v = '0;
    rx_pop_v  = '0;
    if (rx_push) rx_push_v[rx_sel] = 1'b1;
    if (rx_pop)  rx_pop_v[core]    = 1'b1;
  end

  always_comb begin
    resp_next = '0;
    unique case (1'b1)
      is_get:  resp_next = rx_empty ? '1
                         : data_width_p'(rx_mem[core][rx_rptr[core]]);
      is_stat: resp_next = data_width_p'({8'(cur_rx_cnt), 8'(tx_cnt)});
      default: resp_next = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_sel][rx_wptr[rx_sel]] <= rx_data_i;
    if (tx_push) tx_mem[tx_wptr] <= {core, io.cmd_data[7:0]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_core_p; c++) begin
        rx_rptr[c] <= '0;
        rx_wptr[c] <= '0;
        rx_cnt[c]  <= '0;
      end
      tx_rptr     <= '0;
      tx_wptr     <= '0;
      tx_cnt      <= '0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      finish_q    <= '0;
      fail_q      <= '0;
      all_fin_q   <= 1'b0;
    end else begin
      for (int c = 0; c < num_core_p; c++) begin
        if (rx_push_v[c])
          rx_wptr[c] <= rx_aw_lp'((int'(rx_wptr[c]) + 1) % rx_fifo_els_p);
        if (rx_pop_v[c])
          rx_rptr[c] <= rx_aw_lp'((int'(rx_rptr[c]) + 1) % rx_fifo_els_p);
        if (rx_push_v[c] & ~rx_pop_v[c])
          rx_cnt[c] <= rx_cnt[c] + 1'b1;
        else if (~rx_push_v[c] & rx_pop_v[c])
          rx_cnt[c] <= rx_cnt[c] - 1'b1;
      end
      if (tx_push)
        tx_wptr <= tx_aw_lp'((int'(tx_wptr) + 1) % tx_fifo_els_p);
      if (tx_pop)
        tx_rptr <= tx_aw_lp'((int'(tx_rptr) + 1) % tx_fifo_els_p);
      if (tx_push & ~tx_pop)
        tx_cnt <= tx_cnt + 1'b1;
      else if (~tx_push & tx_pop)
        tx_cnt <= tx_cnt - 1'b1;
      if (yumi) begin
        resp_v_q    <= 1'b1;
        resp_data_q <= resp_next;
      end else if (io.resp_ready) begin
        resp_v_q <= 1'b0;
      end
      if (yumi & is_fin) begin
        finish_q[core] <= 1'b1;
        if (io.cmd_data[0]) fail_q[core] <= 1'b1;
      end
      all_fin_q <= &finish_q;
    end
  end

  assign io.resp_v    = resp_v_q;
  assign io.resp_data = resp_data_q;
  assign finish_o       = finish_q;
  assign fail_o         = fail_q;
  assign all_finished_o = all_fin_q;

endmodule

// File: tb/tb_bp_host_io_ctrl.sv
// Randomized and directed bench for bp_host_io_ctrl against a queue-based
// reference model of the host I/O behaviour.
module tb_bp_host_io_ctrl;
  localparam int NC  = 4;
  localparam int RXE = 8;
  localparam int TXE = 16;
  localparam logic [39:0] BASE = 40'h00_0010_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_host_io_ctrl_if #(.paddr_width_p(40), .data_width_p(64)) io ();

  logic [7:0] rx_data;
  logic [1:0] rx_core;
  logic       rx_v, rx_ready;
  logic [7:0] tx_data;
  logic [1:0] tx_core;
  logic       tx_v, tx_ready;
  logic [3:0] finish, fail;
  logic       all_fin;

  bp_host_io_ctrl dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .io             (io),
    .rx_data_i      (rx_data),
    .rx_core_i      (rx_core),
    .rx_v_i         (rx_v),
    .rx_ready_o     (rx_ready),
    .tx_data_o      (tx_data),
    .tx_core_o      (tx_core),
    .tx_v_o         (tx_v),
    .tx_ready_i     (tx_ready),
    .finish_o       (finish),
    .fail_o         (fail),
    .all_finished_o (all_fin)
  );

  logic [7:0]  rxq [NC][$];
  logic [9:0]  txq [$];
  logic [3:0]  m_fin, m_fail;
  logic        m_all, m_rv, m_yumi;
  logic [63:0] m_rdata;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) rxq[c].delete();
    txq.delete();
    m_fin = '0; m_fail = '0; m_all = 1'b0;
    m_rv = 1'b0; m_rdata = '0; m_yumi = 1'b0;
  endtask

  task automatic idle();
    io.cmd_v = 1'b0; io.cmd_wr = 1'b0;
    io.cmd_addr = '0; io.cmd_data = '0;
    io.resp_ready = 1'b1;
    rx_v = 1'b0; rx_core = '0; rx_data = '0;
    tx_ready = 1'b0;
  endtask

  // Called just after a falling edge with inputs set; checks, then
  // advances the model across the next rising edge.
  task automatic tick();
    logic hit, get, put, fin, stat, rx_acc, tx_tk;
    logic [3:0]  f;
    logic [1:0]  c;
    logic [63:0] rd;
    int rc;
    #1;
    hit  = io.cmd_addr[39:16] == BASE[39:16];
    f    = io.cmd_addr[15:12];
    c    = io.cmd_addr[4:3];
    get  = hit && f == 4'd0 && !io.cmd_wr;
    put  = hit && f == 4'd1 &&  io.cmd_wr;
    fin  = hit && f == 4'd2 &&  io.cmd_wr;
    stat = hit && f == 4'd3 && !io.cmd_wr;
    rc   = int'(rx_core);
    m_yumi = io.cmd_v && (!m_rv || io.resp_ready)
             && !(put && txq.size() == TXE);
    chk("yumi", io.cmd_yumi, m_yumi);
    chk("resp_v", io.resp_v, m_rv);
    chk("resp_data", io.resp_data, m_rdata);
    chk("rx_ready", rx_ready, rxq[rc].size() < RXE);
    chk("tx_v", tx_v, txq.size() > 0);
    if (txq.size() > 0) chk("tx_head", {tx_core, tx_data}, txq[0]);
    chk("finish", finish, m_fin);
    chk("fail", fail, m_fail);
    chk("all_fin", all_fin, m_all);

    rd = '0;
    if (get)  rd = (rxq[c].size() > 0) ? {56'd0, rxq[c][0]} : '1;
    if (stat) rd = {48'd0, 8'(rxq[c].size()), 8'(txq.size())};
    rx_acc = rx_v && rxq[rc].size() < RXE;
    tx_tk  = tx_ready && txq.size() > 0;
    m_all  = &m_fin;
    if (m_yumi && get && rxq[c].size() > 0) void'(rxq[c].pop_front());
    if (rx_acc) rxq[rc].push_back(rx_data);
    if (tx_tk) void'(txq.pop_front());
    if (m_yumi && put) txq.push_back({c, io.cmd_data[7:0]});
    if (m_yumi && fin) begin
      m_fin[c] = 1'b1;
      if (io.cmd_data[0]) m_fail[c] = 1'b1;
    end
    if (m_yumi) begin
      m_rv = 1'b1;
      m_rdata = rd;
    end else if (io.resp_ready) begin
      m_rv = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic cmd(input logic wr, input logic [15:0] off,
                     input logic [63:0] data);
    io.cmd_v = 1'b1; io.cmd_wr = wr;
    io.cmd_addr = BASE + 40'(off); io.cmd_data = data;
  endtask

  initial begin
    int n;
    logic [3:0] f;
    logic [1:0] c;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_yumi", io.cmd_yumi, 1'b0);
    chk("rst_tx_v", tx_v, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // status of core 0 right after reset
    cmd(1'b0, 16'h3000, '0); tick();
    idle(); tick();

    // 'A','B' to core 2, then three getchars
    rx_v = 1'b1; rx_core = 2'd2; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      cmd(1'b0, 16'h0010, '0); tick();
    end
    idle(); tick(); tick();

    // 17 putchars from core 1 against a stalled host
    n = 0;
    for (int k = 0; k < 20 && n < 17; k++) begin
      cmd(1'b1, 16'h1008, 64'(8'h60 + n)); tick();
      if (m_yumi) n++;
    end
    chk("tx_fill_cnt", n, 16);
    tx_ready = 1'b1;
    for (int k = 0; k < 10 && n < 17; k++) begin
      cmd(1'b1, 16'h1008, 64'(8'h60 + n)); tick();
      if (m_yumi) n++;
    end
    chk("tx_17th", n, 17);
    io.cmd_v = 1'b0;
    repeat (20) tick();
    idle();

    // core 0 RX full, then push and getchar together
    rx_core = 2'd0;
    for (int i = 0; i < RXE; i++) begin
      rx_v = 1'b1; rx_data = 8'(8'h30 + i); tick();
    end
    rx_data = 8'hEE; cmd(1'b0, 16'h0000, '0); tick();
    idle(); cmd(1'b0, 16'h3000, '0); tick();
    idle(); tick();

    // finish stores, core 1 fails
    for (int i = 0; i < NC; i++) begin
      cmd(1'b1, 16'h2000 + 16'(i * 8), (i == 1) ? 64'd1 : 64'd0); tick();
    end
    idle(); repeat (3) tick();
    cmd(1'b1, 16'h2008, 64'd0); tick();
    idle(); tick();

    // leave bytes in TX, then stall the response path and reset mid-stall
    cmd(1'b1, 16'h1018, 64'h5A); tick();
    cmd(1'b0, 16'h3018, '0); tick();
    io.resp_ready = 1'b0;
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_yumi", io.cmd_yumi, 1'b0);
    chk("arst_resp_v", io.resp_v, 1'b0);
    chk("arst_resp_data", io.resp_data, 64'd0);
    chk("arst_tx_v", tx_v, 1'b0);
    chk("arst_finish", finish, 4'd0);
    chk("arst_fail", fail, 4'd0);
    chk("arst_all_fin", all_fin, 1'b0);
    model_reset();
    idle();
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      f = 4'($urandom_range(0, 5));
      if (f == 4'd2 && $urandom_range(0, 15) != 0) f = 4'd1;
      c = 2'($urandom_range(0, 3));
      io.cmd_v = $urandom_range(0, 99) < 60;
      io.cmd_wr = ($urandom_range(0, 9) < 8) ? (f == 4'd1 || f == 4'd2)
                                             : 1'($urandom);
      io.cmd_addr = {($urandom_range(0, 9) == 0) ? 24'($urandom)
                                                 : BASE[39:16],
                     f, 7'($urandom), c, 3'b000};
      io.cmd_data = {$urandom, $urandom};
      io.resp_ready = $urandom_range(0, 3) != 0;
      rx_v = $urandom_range(0, 1) == 1;
      rx_core = 2'($urandom);
      rx_data = 8'($urandom);
      tx_ready = $urandom_range(0, 9) < 4;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
